// File: rtl/id_ex_register.sv
// ID/EX pipeline register: control word, operands and specifiers with stall, flush and bubble tracking.
// Optional saturating bubble counter on outBubbleCount when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inStall,
    input  logic              inFlush,
    input  logic              inValid,
    input  logic              inRegDst,
    input  logic              inALUSrc,
    input  logic              inBranch,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              inMemToReg,
    input  logic              inRegWrite,
    input  logic [1:0]        inALUOp,
    input  logic [DATA_W-1:0] inPC4,
    input  logic [DATA_W-1:0] inReadData1,
    input  logic [DATA_W-1:0] inReadData2,
    input  logic [DATA_W-1:0] inSignExt,
    input  logic [REG_W-1:0]  inRs,
    input  logic [REG_W-1:0]  inRt,
    input  logic [REG_W-1:0]  inRd,
    output logic              outRegDst,
    output logic              outALUSrc,
    output logic              outBranch,
    output logic              outMemRead,
    output logic              outMemWrite,
    output logic              outMemToReg,
    output logic              outRegWrite,
    output logic [1:0]        outALUOp,
    output logic [DATA_W-1:0] outPC4,
    output logic [DATA_W-1:0] outReadData1,
    output logic [DATA_W-1:0] outReadData2,
    output logic [DATA_W-1:0] outSignExt,
    output logic [REG_W-1:0]  outRs,
    output logic [REG_W-1:0]  outRt,
    output logic [REG_W-1:0]  outRd,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [15:0]       outBubbleCount,
`endif
    output logic              outValid,
    output logic              outBubble
);

    logic [8:0]        r_ctrl;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_sext;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic              r_valid;
    logic              r_bubble;

    logic [8:0]        w_ctrl_in;
    logic              w_load_bubble;
    logic [8:0]        w_ctrl_load;

    assign w_ctrl_in = {inRegDst, inALUSrc, inBranch, inMemRead, inMemWrite,
                        inMemToReg, inRegWrite, inALUOp};
    assign w_load_bubble = ~inValid | (w_ctrl_in == 9'd0);
    // An invalid slot must never carry live control (e.g. a stray MemWrite).
    assign w_ctrl_load = inValid ? w_ctrl_in : 9'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_pc4    <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_sext   <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
            r_bubble <= 1'b1;
        end else if (inFlush) begin
            r_ctrl   <= '0;
            r_pc4    <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_sext   <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
            r_bubble <= 1'b1;
        end else if (!inStall) begin
            r_ctrl   <= w_ctrl_load;
            r_pc4    <= inPC4;
            r_rd1    <= inReadData1;
            r_rd2    <= inReadData2;
            r_sext   <= inSignExt;
            r_rs     <= inRs;
            r_rt     <= inRt;
            r_rd     <= inRd;
            r_valid  <= inValid;
            r_bubble <= w_load_bubble;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic        w_cnt_inc;

    assign w_cnt_inc = inFlush | (~inStall & w_load_bubble);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (w_cnt_inc && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign outBubbleCount = r_bubble_cnt;
`endif

    assign {outRegDst, outALUSrc, outBranch, outMemRead, outMemWrite,
            outMemToReg, outRegWrite, outALUOp} = r_ctrl;
    assign outPC4       = r_pc4;
    assign outReadData1 = r_rd1;
    assign outReadData2 = r_rd2;
    assign outSignExt   = r_sext;
    assign outRs        = r_rs;
    assign outRt        = r_rt;
    assign outRd        = r_rd;
    assign outValid     = r_valid;
    assign outBubble    = r_bubble;

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures the 9-bit control word produced by the hazard bubble multiplexer, together with the decode-stage operands and register specifiers, and presents them to EX one cycle later.
- Supports hold (stall) and flush (squash to bubble).
- Tracks a valid bit so that downstream stages and debug can tell real instructions from inserted bubbles.

Parameters:
- DATA_W, 32, width of PC+4, register operands and sign-extended immediate
- REG_W, 5, width of register specifiers rs/rt/rd

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- inStall  in  1  hold current contents (EX/downstream stall)
- inFlush  in  1  load a bubble (branch taken / exception)
- inValid  in  1  decode-stage instruction valid
- inRegDst, inALUSrc, inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite  in  1 each  control bits from the bubble mux
- inALUOp  in  2  ALU operation class from the bubble mux
- inPC4  in  DATA_W  PC+4 of the decode instruction
- inReadData1, inReadData2  in  DATA_W  register file outputs
- inSignExt  in  DATA_W  sign-extended immediate
- inRs, inRt, inRd  in  REG_W  register specifiers
- outRegDst, outALUSrc, outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite  out  1 each  registered control
- outALUOp  out  2  registered ALU op class
- outPC4, outReadData1, outReadData2, outSignExt  out  DATA_W  registered data
- outRs, outRt, outRd  out  REG_W  registered specifiers
- outValid  out  1  registered instruction valid
- outBubble  out  1  registered flag: the current contents are a bubble

Behaviour:
- Reset (asynchronous, active-high):
  - Every output is 0 immediately, independent of clk.
  - outBubble = 1.
  - Deasserting reset has no effect until the next rising edge.
- Latency: 1 cycle from inputs to outputs. No combinational input-to-output paths.
- Per rising edge, priority is reset > inFlush > inStall > load.
- inFlush = 1:
  - All 9 control bits are cleared, outValid = 0 and outBubble = 1.
  - Data and specifier fields are cleared to 0, so no stale rs/rt reach the forwarding unit.
  - Flush wins over a simultaneous inStall.
- inStall = 1 (no flush): every register holds its value, including outValid and outBubble.
- Load (neither asserted):
  - All fields take their in* values.
  - outValid <= inValid.
  - outBubble <= ~inValid OR (control word all-zero: inRegDst..inRegWrite = 0 and inALUOp = 0).
  - A bubble inserted upstream by the hazard mux (inHazard = 0) therefore registers as outBubble = 1.
  - outValid still follows inValid, so the stalled instruction remains tracked.
- Invariants:
  - outMemWrite = 1 and outRegWrite = 1 never appear while outBubble = 1.
  - Control outputs are all-zero whenever outBubble = 1.
- No wrap-around conditions.
- Reset asserted mid-stall clears everything; the held instruction is lost by design.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- When defined:
  - Adds output outBubbleCount, 16 bits.
  - Increments by 1 on each rising edge where the register loads or flushes a bubble, i.e. the next-state outBubble is 1 and inStall = 0 or inFlush = 1.
  - Saturates at 16'hFFFF and does not wrap.
  - Asynchronously reset to 0.
  - Holds its value during stalls.
- When undefined: the port and the counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert reset mid-cycle with outputs nonzero -> all outputs 0 and outBubble = 1 before the next edge; after release, the first edge loads inputs.
- Normal load: inALUOp = 2'b10, inRegDst = 1, inRegWrite = 1, inReadData1 = 32'h0000_0005, inRt = 5'd9, inValid = 1 -> next cycle outALUOp = 2'b10, outRegWrite = 1, outReadData1 = 5, outRt = 9, outValid = 1, outBubble = 0.
- Stall: load an instruction with outPC4 = 32'h0000_0010, then inStall = 1 for 3 cycles with changing inputs -> outputs unchanged all 3 cycles; inStall = 0 loads the new values.
- Flush vs stall: inFlush = 1 and inStall = 1 together with inMemWrite = 1 -> outMemWrite = 0, all controls 0, outValid = 0, outBubble = 1, outRs/outRt/outRd = 0.
- Upstream bubble: all control inputs 0 with inValid = 1, inRs = 5'd3 -> outBubble = 1, outValid = 1, outRs = 3, controls 0.
- Counter (ID_EX_BUBBLE_CNT_EN): 2 flushes plus 1 upstream bubble, with a stall cycle between them -> outBubbleCount = 3. Preload near saturation by forcing 65535 bubble loads -> the count stays at 16'hFFFF.
